// File: rtl/elbeth_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : elbeth_alu_mc
//  Description : Multi-cycle ALU for the ELBETH execute stage. It takes
//                requests and returns results over valid/ready handshakes,
//                with one operation in flight at a time. Single-cycle ops
//                finish in one cycle. Define ELBETH_ALU_MULDIV_EN to build
//                the iterative MUL/DIVU/REMU datapath (opcodes 10-12).
//                Without the macro, those opcodes are reported as illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module elbeth_alu_mc #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [OPW-1:0]   operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [OPW-1:0] c_OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] c_OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] c_OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] c_OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] c_OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] c_OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] c_OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] c_OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] c_OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] c_OP_SLTU = OPW'(9);
`ifdef ELBETH_ALU_MULDIV_EN
    localparam logic [1:0]     c_BUSY    = 2'd1;
    localparam logic [OPW-1:0] c_OP_MUL  = OPW'(10);
    localparam logic [OPW-1:0] c_OP_DIVU = OPW'(11);
    localparam logic [OPW-1:0] c_OP_REMU = OPW'(12);
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_ill;

    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;
    logic [SHW-1:0]   w_shamt;

    assign w_shamt = data_b[SHW-1:0];

    // Single-cycle result and flags, computed straight from the request inputs
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (operation)
            c_OP_ADD: begin
                w_res = data_a + data_b;
                w_ovf = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != data_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = data_a - data_b;
                w_ovf = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != data_a[WIDTH-1]);
            end
            c_OP_AND:  w_res = data_a & data_b;
            c_OP_OR:   w_res = data_a | data_b;
            c_OP_XOR:  w_res = data_a ^ data_b;
            c_OP_SLL:  w_res = data_a << w_shamt;
            c_OP_SRL:  w_res = data_a >> w_shamt;
            c_OP_SRA:  w_res = $signed(data_a) >>> w_shamt;
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (data_a < data_b)};
`ifdef ELBETH_ALU_MULDIV_EN
            c_OP_MUL, c_OP_DIVU, c_OP_REMU: w_res = '0;
`endif
            default:   w_ill = 1'b1;
        endcase
    end

`ifdef ELBETH_ALU_MULDIV_EN
    // Iteration registers: r_a is the multiplicand/divisor, r_b is the
    // multiplier/dividend, which shifts into the quotient during a divide, and
    // r_acc holds the product/remainder.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [OPW-1:0]   r_op;
    logic [SHW:0]     r_cnt;

    logic             w_long;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_diff;
    logic [WIDTH-1:0] w_nxt_a;
    logic [WIDTH-1:0] w_nxt_b;
    logic [WIDTH-1:0] w_nxt_acc;
    logic [WIDTH-1:0] w_fin;

    assign w_long = (operation == c_OP_MUL) || (operation == c_OP_DIVU) ||
                    (operation == c_OP_REMU);

    // One shift-add or restoring-subtract step. The last step's output
    // feeds the result register directly.
    always_comb begin
        w_rem_sh   = {r_acc, r_b[WIDTH-1]};
        w_rem_diff = w_rem_sh - {1'b0, r_a};
        w_nxt_a    = r_a;
        w_nxt_b    = r_b;
        w_nxt_acc  = r_acc;
        if (r_op == c_OP_MUL) begin
            w_nxt_acc = r_b[0] ? (r_acc + r_a) : r_acc;
            w_nxt_a   = r_a << 1;
            w_nxt_b   = r_b >> 1;
        end else if (!w_rem_diff[WIDTH]) begin
            w_nxt_acc = w_rem_diff[WIDTH-1:0];
            w_nxt_b   = {r_b[WIDTH-2:0], 1'b1};
        end else begin
            w_nxt_acc = w_rem_sh[WIDTH-1:0];
            w_nxt_b   = {r_b[WIDTH-2:0], 1'b0};
        end
        w_fin = (r_op == c_OP_DIVU) ? w_nxt_b : w_nxt_acc;
    end
`endif

    // Control FSM plus the result/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
`ifdef ELBETH_ALU_MULDIV_EN
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
`ifdef ELBETH_ALU_MULDIV_EN
                        if (w_long) begin
                            r_a     <= data_b;
                            r_b     <= data_a;
                            r_acc   <= '0;
                            r_op    <= operation;
                            r_cnt   <= (SHW+1)'(WIDTH);
                            r_state <= c_BUSY;
                        end else
`endif
                        begin
                            r_result <= w_res;
                            r_zero   <= (w_res == '0);
                            r_ovf    <= w_ovf;
                            r_ill    <= w_ill;
                            r_state  <= c_DONE;
                        end
                    end
                end
`ifdef ELBETH_ALU_MULDIV_EN
                c_BUSY: begin
                    r_a   <= w_nxt_a;
                    r_b   <= w_nxt_b;
                    r_acc <= w_nxt_acc;
                    r_cnt <= r_cnt - (SHW+1)'(1);
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_result <= w_fin;
                        r_zero   <= (w_fin == '0);
                        r_ovf    <= 1'b0;
                        r_ill    <= 1'b0;
                        r_state  <= c_DONE;
                    end
                end
`endif
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == c_IDLE) && !rst;
    assign out_valid  = (r_state == c_DONE);
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign overflow   = r_ovf;
    assign illegal    = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_elbeth_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elbeth_alu_mc
//  Description : Self-checking bench for elbeth_alu_mc (WIDTH=32). It runs
//                directed vectors, handshake and reset corner sequences, and
//                random ops. Results are compared against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elbeth_alu_mc;

    localparam int W = 32;
`ifdef ELBETH_ALU_MULDIV_EN
    localparam bit c_MD = 1'b1;
`else
    localparam bit c_MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [3:0]   operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int n_vec = 0;
    int n_err = 0;

    elbeth_alu_mc #(.WIDTH(W), .OPW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_result(alu_result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         o;
        logic         il;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model built from the opcode definitions, using 64-bit integer arithmetic
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic o, output logic il, output int lat);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint t;
        r = '0; o = 1'b0; il = 1'b0; lat = 1;
        case (op)
            4'd0: begin t = sa + sb; r = W'(ua + ub);
                        o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd1: begin t = sa - sb; r = W'(ua - ub);
                        o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = W'(ua << (ub % W));
            4'd6: r = W'(ua >> (ub % W));
            4'd7: r = W'(sa >>> (ub % W));
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = (ua < ub) ? 1 : 0;
            4'd10: if (c_MD) begin r = W'(ua * ub); lat = W + 1; end else il = 1'b1;
            4'd11: if (c_MD) begin r = (ub == 0) ? '1 : W'(ua / ub); lat = W + 1; end
                   else il = 1'b1;
            4'd12: if (c_MD) begin r = (ub == 0) ? a : W'(ua % ub); lat = W + 1; end
                   else il = 1'b1;
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one op with out_ready held high, then check its result, flags, latency and 1-cycle valid pulse
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic eo, input logic ei,
                          input int elat, input string nm);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        chk({nm, "_rdy"}, in_ready, 1);
        in_valid = 1'b1; operation = op; data_a = a; data_b = b; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; data_a = $urandom; data_b = $urandom; operation = 4'($urandom);
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_res"}, alu_result, er);
        chk({nm, "_zero"}, zero, (er == '0));
        chk({nm, "_ovf"}, overflow, eo);
        chk({nm, "_ill"}, illegal, ei);
        @(negedge clk);
        chk({nm, "_pulse"}, out_valid, 0);
    endtask

    task automatic run_model(input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input string nm);
        logic [W-1:0] r; logic o; logic il; int lat;
        model(op, a, b, r, o, il, lat);
        run_op(op, a, b, r, o, il, lat, nm);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] sp[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        vec_t tbl[$];
        bit   seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        data_a = '0; data_b = '0; operation = '0;

        tbl.push_back('{4'd0,  32'd3,          32'd4,  32'd7,          1'b0, 1'b0});
        tbl.push_back('{4'd1,  32'd5,          32'd2,  32'd3,          1'b0, 1'b0});
        tbl.push_back('{4'd1,  32'd7,          32'd7,  32'd0,          1'b0, 1'b0});
        tbl.push_back('{4'd0,  32'h7FFFFFFF,   32'd1,  32'h80000000,   1'b1, 1'b0});
        tbl.push_back('{4'd1,  32'h80000000,   32'd1,  32'h7FFFFFFF,   1'b1, 1'b0});
        tbl.push_back('{4'd0,  32'hFFFFFFFF,   32'd1,  32'd0,          1'b0, 1'b0});
        tbl.push_back('{4'd3,  32'hA,          32'h5,  32'hF,          1'b0, 1'b0});
        tbl.push_back('{4'd2,  32'hF0F0,       32'hFF00, 32'hF000,     1'b0, 1'b0});
        tbl.push_back('{4'd4,  32'hFF,         32'h0F, 32'hF0,         1'b0, 1'b0});
        tbl.push_back('{4'd7,  32'h80000000,   32'd4,  32'hF8000000,   1'b0, 1'b0});
        tbl.push_back('{4'd6,  32'h80000000,   32'd4,  32'h08000000,   1'b0, 1'b0});
        tbl.push_back('{4'd5,  32'd1,          32'd33, 32'd2,          1'b0, 1'b0});
        tbl.push_back('{4'd8,  32'hFFFFFFFF,   32'd1,  32'd1,          1'b0, 1'b0});
        tbl.push_back('{4'd9,  32'hFFFFFFFF,   32'd1,  32'd0,          1'b0, 1'b0});
        tbl.push_back('{4'd13, 32'd5,          32'd6,  32'd0,          1'b0, 1'b1});
        tbl.push_back('{4'd15, 32'd5,          32'd6,  32'd0,          1'b0, 1'b1});
        tbl.push_back('{4'd10, 32'd6,          32'd7,  c_MD ? 32'd42 : 32'd0,         1'b0, !c_MD});
        tbl.push_back('{4'd11, 32'd100,        32'd7,  c_MD ? 32'd14 : 32'd0,         1'b0, !c_MD});
        tbl.push_back('{4'd12, 32'd100,        32'd7,  c_MD ? 32'd2  : 32'd0,         1'b0, !c_MD});
        tbl.push_back('{4'd11, 32'd12345,      32'd0,  c_MD ? 32'hFFFFFFFF : 32'd0,   1'b0, !c_MD});
        tbl.push_back('{4'd12, 32'd12345,      32'd0,  c_MD ? 32'd12345 : 32'd0,      1'b0, !c_MD});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_res", alu_result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ill", illegal, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", in_ready, 1);

        // Directed vectors
        foreach (tbl[i]) begin
            int el = ((tbl[i].op >= 4'd10) && (tbl[i].op <= 4'd12) && c_MD) ? W + 1 : 1;
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].o, tbl[i].il, el,
                   $sformatf("vec%0d", i));
        end

        // Back-pressure: the result is held and new requests are ignored
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; operation = 4'd3; data_a = 32'hA; data_b = 32'h5;
        @(negedge clk);
        chk("bp_valid0", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; operation = 4'd0; data_a = 32'd3; data_b = 32'd4;
            @(negedge clk);
            chk($sformatf("bp_valid%0d", k + 1), out_valid, 1);
            chk($sformatf("bp_res%0d", k + 1), alu_result, 32'hF);
            chk($sformatf("bp_rdy%0d", k + 1), in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_taken", out_valid, 0);
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        chk("bp_nodup", seen, 0);

        // Reset while DONE drops the result
        in_valid = 1'b1; out_ready = 1'b0; operation = 4'd0; data_a = 32'd3; data_b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rd_valid_pre", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rd_valid", out_valid, 0);
        chk("rd_res", alu_result, 0);
        chk("rd_zero", zero, 0);
        rst = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        chk("rd_noresult", seen, 0);
        chk("rd_ready", in_ready, 1);

`ifdef ELBETH_ALU_MULDIV_EN
        // Reset in the middle of a MUL aborts it
        in_valid = 1'b1; operation = 4'd10; data_a = 32'd6; data_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rb_valid", out_valid, 0);
        chk("rb_res", alu_result, 0);
        chk("rb_zero", zero, 0);
        chk("rb_ovf", overflow, 0);
        chk("rb_ill", illegal, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        chk("rb_noresult", seen, 0);
`endif
        run_op(4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, "post_rst_add");

        // Random ops against the model
        for (int n = 0; n < 200; n++) begin
            logic [3:0]   op = 4'($urandom_range(0, 15));
            logic [W-1:0] a  = pick();
            logic [W-1:0] b  = pick();
            if (op >= 4'd11 && op <= 4'd12 && $urandom_range(0, 7) == 0) b = '0;
            run_model(op, a, b, $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so a stuck DUT cannot hang the run
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
